// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, state/action encodings and helpers for the fetch stage.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int          IMEM_SIZE_DEF = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_FETCH,
        ACT_STALL,
        ACT_REDIRECT,
        ACT_HALT,
        ACT_RESUME,
        ACT_FAULT
    } act_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Next-PC selection and fault detection for the fetch stage.
// Picks one action per edge by priority: fault, redirect, halt, stall, fetch.
module next_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int IMEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic [31:0] pc,
    input  logic [1:0]  state,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic [31:0] pc_inc,
    output logic [2:0]  act
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_SIZE) << 2;

    logic pc_oor;
    act_e act_d;

    assign pc_inc = pc + 32'd4;
    assign pc_oor = ({1'b0, pc} >= PC_LIMIT);
    assign act    = act_d;

    always_comb begin
        act_d   = ACT_IDLE;
        pc_next = pc;
        unique case (state_e'(state))
            ST_RUN, ST_FLUSH: begin
                if (pc_oor) begin
                    act_d = ACT_FAULT;
                end else if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        act_d = ACT_FAULT;
                    end else begin
                        act_d   = ACT_REDIRECT;
                        pc_next = redirect_pc;
                    end
                end else if (halt_req) begin
                    act_d = ACT_HALT;
                end else if (stall) begin
                    act_d = ACT_STALL;
                end else begin
                    act_d   = ACT_FETCH;
                    pc_next = pc_inc;
                end
            end
            ST_HALT: begin
                // resume outranks halt_req; everything else is ignored here
                if (resume) begin
                    act_d = ACT_RESUME;
                end
            end
            ST_FAULT: begin
                act_d = ACT_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, RUN/FLUSH/HALT/FAULT FSM,
// IF/ID instruction register and saturating delivered-instruction counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          IMEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] Ins,
    output logic [31:0] nextPC,
    output logic        ins_valid,
    output logic [1:0]  state,
    output logic [31:0] fetch_count
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] npc_q, npc_d;
    logic        vld_q, vld_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [2:0]  act_raw;
    act_e        act;

    assign act = act_e'(act_raw);

    next_pc_sel #(
        .IMEM_SIZE (IMEM_SIZE)
    ) u_next_pc_sel (
        .pc             (pc_q),
        .state          (state_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_next        (pc_next),
        .pc_inc         (pc_inc),
        .act            (act_raw)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        npc_d   = npc_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        unique case (act)
            ACT_FETCH: begin
                ins_d   = imem_rdata;
                npc_d   = pc_inc;
                vld_d   = 1'b1;
                pc_d    = pc_next;
                state_d = ST_RUN;
                cnt_d   = sat_inc(cnt_q);
            end
            ACT_REDIRECT: begin
                pc_d    = pc_next;
                ins_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_FLUSH;
            end
            ACT_HALT: begin
                ins_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_HALT;
            end
            ACT_FAULT: begin
                ins_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_FAULT;
            end
            ACT_RESUME: begin
                state_d = ST_RUN;
            end
            ACT_STALL, ACT_IDLE: begin
                state_d = state_q;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            npc_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            npc_q   <= npc_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign Ins         = ins_q;
    assign nextPC      = npc_q;
    assign ins_valid   = vld_q;
    assign state       = state_q;
    assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IMEM_SIZE, default taken from common_param.vh, instruction memory depth in words.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port redirect_valid  in  1  taken branch/jump/jr from EX.
REQ-006 SHALL have port redirect_pc  in  32  redirect target byte address.
REQ-007 SHALL have port stall  in  1  hold request from hazard unit (load-use).
REQ-008 SHALL have port halt_req  in  1  stop fetching.
REQ-009 SHALL have port resume  in  1  leave HALT.
REQ-010 SHALL have port imem_rdata  in  32  combinational IMEM read data for imem_addr.
REQ-011 SHALL have port imem_addr  out  32  current PC, byte address, combinational from PC register.
REQ-012 SHALL have port Ins  out  32  registered IF/ID instruction.
REQ-013 SHALL have port nextPC  out  32  registered PC+4 of Ins.
REQ-014 SHALL have port ins_valid  out  1  Ins is a real instruction (0 = bubble, Ins = NOP 0).
REQ-015 SHALL have port state  out  2  RUN=0, FLUSH=1, HALT=2, FAULT=3.
REQ-016 SHALL have port fetch_count  out  32  number of valid instructions delivered, saturating at 32'hFFFF_FFFF.

Function
REQ-017 SHALL evaluate per edge, highest priority first: RST, fault check, redirect_valid, halt_req, stall, sequential fetch.
REQ-018 Sequential fetch (RUN or FLUSH, no other event): Ins<=imem_rdata, nextPC<=PC+4, ins_valid<=1, PC<=PC+4, state<=RUN.
REQ-019 Stall in RUN/FLUSH: PC, Ins, nextPC, ins_valid, state, fetch_count held unchanged.
REQ-020 Redirect in RUN/FLUSH (redirect_pc word-aligned, in range): PC<=redirect_pc, Ins<=0, ins_valid<=0, state<=FLUSH; stall same cycle ignored.
REQ-021 FLUSH SHALL last exactly one cycle; target instruction is latched on that edge and shown with ins_valid=1 the following cycle (one-bubble redirect penalty).
REQ-022 Back-to-back redirects: each one reloads PC and restarts FLUSH; no instruction from the overridden path is ever marked valid.
REQ-023 halt_req in RUN/FLUSH (no redirect): PC held, ins_valid<=0, Ins<=0, state<=HALT.
REQ-024 In HALT: redirect_valid, stall, halt_req ignored; resume=1 -> state<=RUN, PC unchanged, fetch resumes the next edge; halt_req and resume together -> resume wins.
REQ-025 Fault: redirect_pc[1:0]!=0 on an accepted redirect, or PC >= IMEM_SIZE*4 in RUN/FLUSH -> state<=FAULT, ins_valid<=0, Ins<=0, PC held at last legal value.
REQ-026 FAULT SHALL be sticky; only RST exits it.
REQ-027 PC+4 SHALL wrap modulo 2^32; the out-of-range check applies after the wrap.
REQ-028 fetch_count SHALL increment on every edge where ins_valid is set to 1 by a fetch, never while held by stall.
REQ-029 imem_addr SHALL equal PC in all states; IMEM word index = PC>>2, computed outside this block.

Reset
REQ-030 RST high at an edge: PC<=RESET_PC, Ins<=0, nextPC<=0, ins_valid<=0, state<=RUN, fetch_count<=0, regardless of state (FAULT/HALT/mid-FLUSH included).
REQ-031 First valid instruction SHALL be IMEM[RESET_PC>>2], latched on the first edge with RST low and shown with ins_valid=1 after that edge.

Structure
REQ-032 IMEM_SIZE, RESET_PC default and state encodings SHALL live in common_param.vh.
REQ-033 Next-PC selection and fault check SHALL be a combinational sub-module next_pc_sel; the FSM and IF/ID register stay in fetch_ctrl.

Verification
REQ-034 Reset then 4 free-run cycles, IMEM[i]=i+100 -> Ins 100,101,102,103; nextPC 4,8,12,16; fetch_count=4.
REQ-035 Redirect to 32'h40 at PC=8 -> one cycle with ins_valid=0 and state=FLUSH, then Ins=IMEM[16], nextPC=32'h44.
REQ-036 Stall 3 cycles at PC=12 plus redirect in the 2nd stall cycle -> redirect taken, stall ignored, FLUSH follows, fetch_count frozen during the stall.
REQ-037 halt_req at PC=20, resume after 5 cycles -> ins_valid=0 and PC=20 throughout HALT; redirect during HALT has no effect; IMEM[5] is delivered after resume.
REQ-038 Redirect to 32'h42 -> state=FAULT, PC unchanged, ins_valid=0, held until RST; RST then returns PC=RESET_PC and state=RUN.
REQ-039 Run to PC=IMEM_SIZE*4-4 -> last word delivered, then FAULT on the out-of-range PC.
